// File: rtl/ex_mem_skid_stage.sv
// ex_mem_skid_stage: EX -> MEM pipeline register with a two-entry skid buffer.
// Holds the ALU result and writeback control in a head (H) and skid (S) entry,
// and owns the architectural NZCV flag register. Flags commit when EX hands an
// entry over, not when MEM consumes it.
// Optional build macro EX_MEM_FWD_EN adds hazard-bypass outputs describing the
// youngest buffered entry that will write a register.
module ex_mem_skid_stage #(
    parameter int DATA_W = 256,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [3:0]        in_flags,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_vec,
    input  logic              in_we,
    input  logic              in_flag_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_vec,
    output logic              out_we,
    output logic [3:0]        nzcv,
    output logic [1:0]        count
`ifdef EX_MEM_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_rd,
    output logic [DATA_W-1:0] fwd_result,
    output logic              fwd_vec
`endif
);

    // Skid entry; the head entry lives directly in the out_* registers.
    logic [DATA_W-1:0] s_result;
    logic [REG_W-1:0]  s_rd;
    logic              s_vec;
    logic              s_we;

    logic accept;
    logic pop;

    // Ready depends only on registered occupancy and flush, so EX never sees
    // a combinational path from MEM's ready.
    assign in_ready  = (count < 2'd2) && !flush;
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Occupancy, entry storage and flag register update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= 2'd0;
            out_result <= '0;
            out_rd     <= '0;
            out_vec    <= 1'b0;
            out_we     <= 1'b0;
            s_result   <= '0;
            s_rd       <= '0;
            s_vec      <= 1'b0;
            s_we       <= 1'b0;
            nzcv       <= 4'b0000;
        end else begin
            if (accept && in_flag_we) begin
                nzcv <= in_flags;
            end
            if (flush) begin
                count <= 2'd0;
            end else begin
                case (count)
                    2'd0: begin
                        if (accept) begin
                            out_result <= in_result;
                            out_rd     <= in_rd;
                            out_vec    <= in_vec;
                            out_we     <= in_we;
                            count      <= 2'd1;
                        end
                    end
                    2'd1: begin
                        if (accept && pop) begin
                            out_result <= in_result;
                            out_rd     <= in_rd;
                            out_vec    <= in_vec;
                            out_we     <= in_we;
                        end else if (accept) begin
                            s_result <= in_result;
                            s_rd     <= in_rd;
                            s_vec    <= in_vec;
                            s_we     <= in_we;
                            count    <= 2'd2;
                        end else if (pop) begin
                            count <= 2'd0;
                        end
                    end
                    2'd2: begin
                        if (pop) begin
                            out_result <= s_result;
                            out_rd     <= s_rd;
                            out_vec    <= s_vec;
                            out_we     <= s_we;
                            count      <= 2'd1;
                        end
                    end
                    default: begin
                        count <= 2'd0;
                    end
                endcase
            end
        end
    end

`ifdef EX_MEM_FWD_EN
    // Bypass source: the skid entry is younger than the head, so it wins when
    // both will write.
    always_comb begin
        fwd_valid  = 1'b0;
        fwd_rd     = out_rd;
        fwd_result = out_result;
        fwd_vec    = out_vec;
        if (count == 2'd2 && s_we) begin
            fwd_valid  = 1'b1;
            fwd_rd     = s_rd;
            fwd_result = s_result;
            fwd_vec    = s_vec;
        end else if (count != 2'd0 && out_we) begin
            fwd_valid  = 1'b1;
        end
        if (flush) begin
            fwd_valid = 1'b0;
        end
    end
`endif

endmodule
